// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer and the control unit:
// state encoding, opcode constants and the opcode legality rule.
package instr_sequencer_pkg;

    localparam int unsigned OPCODE_WIDTH = 5;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'd0;
    localparam opcode_t OP_ADD  = 5'd1;
    localparam opcode_t OP_SUB  = 5'd2;
    localparam opcode_t OP_AND  = 5'd3;
    localparam opcode_t OP_OR   = 5'd4;
    localparam opcode_t OP_ADDI = 5'd5;
    localparam opcode_t OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    // Legal opcodes form a contiguous block starting at NOP.
    function automatic logic op_is_legal(input opcode_t op);
        return op <= OP_ADDI;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake: req/addr from the sequencer,
// ack/data from the memory.
interface instr_sequencer_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   ack;
    logic [INSTR_WIDTH-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC,
// instruction register, halt/illegal status and retired-instruction count.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_run,
    instr_sequencer_if.master       imem,
    output logic [INSTR_WIDTH-1:0]  out_instr,
    output logic [OPCODE_WIDTH-1:0] out_op_code,
    input  logic                    in_ctrl_reg_file_wr_en,
    output logic                    out_reg_file_wr_en,
    output logic [PC_WIDTH-1:0]     out_pc,
    output logic                    out_halted,
    output logic                    out_illegal,
    output logic [CNT_WIDTH-1:0]    out_retired_count
);

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   illegal_q, illegal_d;
    logic                   fetch_req;
    logic                   wr_en;
    opcode_t                op;

    assign op = instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        fetch_req = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (imem.ack) begin
                    instr_d = imem.data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // HALT and illegal opcodes stop without advancing PC or count.
                if (op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op_is_legal(op)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                wr_en   = in_ctrl_reg_file_wr_en;
                pc_d    = pc_q + PC_WIDTH'(1);
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = in_run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and write enable decode from the state register only, so
    // reset clears them in the same cycle.
    assign imem.req           = fetch_req;
    assign imem.addr          = pc_q;
    assign out_reg_file_wr_en = wr_en;
    assign out_instr          = instr_q;
    assign out_op_code        = op;
    assign out_pc             = pc_q;
    assign out_halted         = (state_q == ST_HALT);
    assign out_illegal        = illegal_q;
    assign out_retired_count  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer: a program-level model
// predicts fetch/retire/halt events, a monitor pops and compares them.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int unsigned PW = 8;
    localparam int unsigned IW = 16;
    localparam int unsigned CW = 16;
    localparam int EV_F = 0;
    localparam int EV_R = 1;
    localparam int EV_H = 2;

    typedef struct {
        int          kind;
        int unsigned addr;
        logic [IW-1:0] instr;
        bit          wr;
        int unsigned cnt;
        bit          ill;
    } ev_t;

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b1;
    logic          in_run = 1'b0;
    logic          ctrl_wr;
    logic [IW-1:0] out_instr;
    logic [4:0]    out_op_code;
    logic          out_reg_file_wr_en;
    logic [PW-1:0] out_pc;
    logic          out_halted;
    logic          out_illegal;
    logic [CW-1:0] out_retired_count;

    instr_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) imem ();

    instr_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .in_clk                 (in_clk),
        .in_rst                 (in_rst),
        .in_run                 (in_run),
        .imem                   (imem),
        .out_instr              (out_instr),
        .out_op_code            (out_op_code),
        .in_ctrl_reg_file_wr_en (ctrl_wr),
        .out_reg_file_wr_en     (out_reg_file_wr_en),
        .out_pc                 (out_pc),
        .out_halted             (out_halted),
        .out_illegal            (out_illegal),
        .out_retired_count      (out_retired_count)
    );

    always #5 in_clk = ~in_clk;

    // Bench-side control unit: NOP writes nothing, other legal ops write.
    assign ctrl_wr = (out_op_code >= 5'd1) && (out_op_code <= 5'd5);

    logic [IW-1:0] mem [256];
    int unsigned   dly [256];
    ev_t           sb[$];
    int            wr_cyc[$];
    int            cyc = 0;
    int            first_req = -1;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic ev_t pop_ev(string who);
        ev_t e;
        e.kind = -1; e.addr = 0; e.instr = '0; e.wr = 0; e.cnt = 0; e.ill = 0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event, scoreboard empty (t=%0t)", who, $time);
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    // Program-level reference: walk memory from address 0 applying the
    // opcode rules; timing and in_run do not change the event order.
    task automatic build_expect(input int max_ev);
        int unsigned   pc = 0;
        int unsigned   cnt = 0;
        int            n = 0;
        logic [IW-1:0] w;
        int unsigned   op;
        ev_t           e;
        while (n < max_ev) begin
            e.kind = EV_F; e.addr = pc; e.instr = '0; e.wr = 0; e.cnt = cnt; e.ill = 0;
            sb.push_back(e); n++;
            if (n >= max_ev) break;
            w  = mem[pc];
            op = int'(w[IW-1 -: 5]);
            if (op == 31 || op > 5) begin
                e.kind = EV_H; e.addr = pc; e.cnt = cnt; e.ill = (op != 31);
                sb.push_back(e);
                break;
            end
            pc  = (pc + 1) % 256;
            cnt = cnt + 1;
            e.kind = EV_R; e.addr = pc; e.instr = w; e.wr = (op != 0); e.cnt = cnt; e.ill = 0;
            sb.push_back(e); n++;
        end
    endtask

    // Memory model: decides ack shortly after each rising edge.
    initial begin
        int unsigned wcnt = 0;
        imem.ack  = 1'b0;
        imem.data = '0;
        forever begin
            @(posedge in_clk);
            #2;
            if (imem.req) begin
                if (wcnt == dly[imem.addr]) begin
                    imem.ack  = 1'b1;
                    imem.data = mem[imem.addr];
                    wcnt      = 0;
                end else begin
                    imem.ack  = 1'b0;
                    imem.data = IW'($urandom);
                    wcnt++;
                end
            end else begin
                imem.ack  = 1'b0;
                imem.data = IW'($urandom);
                wcnt      = 0;
            end
        end
    end

    // Monitor
    initial begin
        logic          p_req, p_ack, p_wr, p_halt, saw_wr;
        logic [PW-1:0] p_addr;
        logic [CW-1:0] p_cnt;
        logic [IW-1:0] p_instr;
        ev_t           e;
        forever begin
            @(negedge in_clk);
            if (!mon_en) begin
                p_req = 0; p_ack = 0; p_wr = 0; p_halt = 0; saw_wr = 0;
                p_addr = '0; p_cnt = '0; p_instr = '0;
                continue;
            end
            check("wr_en_single_cycle", {63'd0, p_wr & out_reg_file_wr_en}, 64'd0);
            if (out_reg_file_wr_en) begin
                saw_wr = 1;
                wr_cyc.push_back(cyc);
            end
            if (first_req < 0 && imem.req) first_req = cyc;
            if (p_req && !p_ack) begin
                check("req_held", {63'd0, imem.req}, 64'd1);
                check("addr_held", {56'd0, imem.addr}, {56'd0, p_addr});
                check("instr_not_latched_early", {48'd0, out_instr}, {48'd0, p_instr});
            end
            if (out_retired_count != p_cnt) begin
                e = pop_ev("retire");
                check("retire_kind", 64'(e.kind), 64'(EV_R));
                check("retire_pc", {56'd0, out_pc}, 64'(e.addr));
                check("retire_count", {48'd0, out_retired_count}, 64'(e.cnt));
                check("retire_instr", {48'd0, out_instr}, {48'd0, e.instr});
                check("retire_wr_en", {63'd0, saw_wr}, {63'd0, e.wr});
                saw_wr = 0;
            end
            if (imem.req && imem.ack) begin
                e = pop_ev("fetch");
                check("fetch_kind", 64'(e.kind), 64'(EV_F));
                check("fetch_addr", {56'd0, imem.addr}, 64'(e.addr));
                check("fetch_addr_is_pc", {56'd0, imem.addr}, {56'd0, out_pc});
            end
            if (out_halted && !p_halt) begin
                e = pop_ev("halt");
                check("halt_kind", 64'(e.kind), 64'(EV_H));
                check("halt_pc", {56'd0, out_pc}, 64'(e.addr));
                check("halt_count", {48'd0, out_retired_count}, 64'(e.cnt));
                check("halt_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                check("halt_no_wr", {63'd0, saw_wr}, 64'd0);
            end
            if (out_halted) begin
                check("halted_req_low", {63'd0, imem.req}, 64'd0);
                check("halted_wr_low", {63'd0, out_reg_file_wr_en}, 64'd0);
            end
            p_req = imem.req; p_ack = imem.ack; p_wr = out_reg_file_wr_en;
            p_halt = out_halted; p_addr = imem.addr; p_cnt = out_retired_count;
            p_instr = out_instr;
        end
    end

    task automatic check_reset_values(string tag);
        check({tag, "_req"}, {63'd0, imem.req}, 64'd0);
        check({tag, "_wr_en"}, {63'd0, out_reg_file_wr_en}, 64'd0);
        check({tag, "_halted"}, {63'd0, out_halted}, 64'd0);
        check({tag, "_illegal"}, {63'd0, out_illegal}, 64'd0);
        check({tag, "_pc"}, {56'd0, out_pc}, 64'd0);
        check({tag, "_instr"}, {48'd0, out_instr}, 64'd0);
        check({tag, "_count"}, {48'd0, out_retired_count}, 64'd0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        in_run = 0;
        @(negedge in_clk);
        #1 in_rst = 1;
        #1 check_reset_values("reset");
        @(negedge in_clk);
        in_rst = 0;
        sb.delete();
        wr_cyc.delete();
        first_req = -1;
        mon_en = 1;
    endtask

    task automatic drain(input int max_cycles, input bit rand_run);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            @(negedge in_clk);
            if (rand_run) in_run = ($urandom_range(0, 3) != 0);
        end
        check("drain_remaining_events", 64'(sb.size()), 64'd0);
    endtask

    task automatic fill_default();
        for (int unsigned i = 0; i < 256; i++) begin
            mem[i] = {5'd31, 11'd0};
            dly[i] = 0;
        end
    endtask

    task automatic small_prog(input logic [4:0] op0, input logic [4:0] op1, input logic [4:0] op2);
        fill_default();
        mem[0] = {op0, 11'h123};
        mem[1] = {op1, 11'h456};
        mem[2] = {op2, 11'h789};
    endtask

    task automatic check_wr_timing(string tag, input int exp0, input int exp1);
        check({tag, "_wr_pulses"}, 64'(wr_cyc.size()), 64'd2);
        if (wr_cyc.size() == 2) begin
            check({tag, "_wr_cycle0"}, 64'(wr_cyc[0] - first_req + 1), 64'(exp0));
            check({tag, "_wr_cycle1"}, 64'(wr_cyc[1] - first_req + 1), 64'(exp1));
        end
    endtask

    initial begin
        logic [4:0] op;
        int         k;

        // ADD, SUB, HALT with zero-wait memory
        small_prog(5'd1, 5'd2, 5'd31);
        do_reset();
        build_expect(100);
        in_run = 1;
        drain(200, 0);
        repeat (2) @(negedge in_clk);
        check("s1_halted", {63'd0, out_halted}, 64'd1);
        check("s1_pc", {56'd0, out_pc}, 64'd2);
        check("s1_count", {48'd0, out_retired_count}, 64'd2);
        check_wr_timing("s1", 4, 8);

        // Three wait cycles on address 1
        small_prog(5'd1, 5'd2, 5'd31);
        dly[1] = 3;
        do_reset();
        build_expect(100);
        in_run = 1;
        drain(200, 0);
        check_wr_timing("s2", 4, 11);

        // Illegal opcode 9 at address 0; in_run toggles afterwards
        small_prog(5'd9, 5'd1, 5'd1);
        do_reset();
        build_expect(100);
        in_run = 1;
        drain(200, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge in_clk);
            in_run = ~in_run;
        end
        check("s3_halted", {63'd0, out_halted}, 64'd1);
        check("s3_illegal", {63'd0, out_illegal}, 64'd1);
        check("s3_count", {48'd0, out_retired_count}, 64'd0);
        check("s3_pc", {56'd0, out_pc}, 64'd0);
        check("s3_no_wr", 64'(wr_cyc.size()), 64'd0);

        // PC wrap: 256 legal instructions ending in a NOP at 255
        fill_default();
        for (int unsigned i = 0; i < 255; i++) begin
            op = 5'($urandom_range(0, 5));
            mem[i] = {op, 11'($urandom)};
            dly[i] = $urandom_range(0, 2);
        end
        mem[255] = {5'd0, 11'($urandom)};
        do_reset();
        build_expect(2 * 256 + 1);
        in_run = 1;
        drain(20000, 1);
        check("s4_pc_wrapped", {56'd0, out_pc}, 64'd0);
        check("s4_count", {48'd0, out_retired_count}, 64'd256);

        // Drop in_run during EXECUTE of the first instruction
        small_prog(5'd1, 5'd1, 5'd31);
        do_reset();
        build_expect(100);
        in_run = 1;
        k = 0;
        while (!(imem.req && imem.ack) && k < 50) begin
            @(negedge in_clk);
            k++;
        end
        check("s5_first_ack_seen", {63'd0, imem.req && imem.ack}, 64'd1);
        @(negedge in_clk);
        @(negedge in_clk);
        in_run = 0;
        repeat (6) @(negedge in_clk);
        check("s5_idle_req", {63'd0, imem.req}, 64'd0);
        check("s5_idle_pc", {56'd0, out_pc}, 64'd1);
        check("s5_idle_count", {48'd0, out_retired_count}, 64'd1);
        check("s5_idle_wr_pulses", 64'(wr_cyc.size()), 64'd1);
        in_run = 1;
        drain(200, 0);

        // Random programs with random waits and in_run activity
        for (int it = 0; it < 6; it++) begin
            fill_default();
            for (int unsigned i = 0; i < 256; i++) begin
                k = $urandom_range(0, 99);
                if (k < 85)      op = 5'($urandom_range(0, 5));
                else if (k < 93) op = 5'd31;
                else             op = 5'($urandom_range(6, 30));
                mem[i] = {op, 11'($urandom)};
                dly[i] = $urandom_range(0, 3);
            end
            do_reset();
            build_expect(600);
            in_run = 1;
            drain(8000, 1);
        end

        // Asynchronous reset while a fetch is waiting
        small_prog(5'd1, 5'd2, 5'd31);
        dly[1] = 30;
        do_reset();
        build_expect(2);
        in_run = 1;
        drain(200, 0);
        k = 0;
        while (!(imem.req && imem.addr == 8'd1) && k < 20) begin
            @(negedge in_clk);
            k++;
        end
        check("s7_req_before_reset", {63'd0, imem.req}, 64'd1);
        mon_en = 0;
        #2 in_rst = 1;
        #1 check_reset_values("s7_async");
        @(negedge in_clk);
        in_rst = 0;
        repeat (2) @(negedge in_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
